// File: rtl/simmem_wburst_tracker.sv
// simmem_wburst_tracker
//   Write-path front end of the simulated memory controller. Each accepted
//   write address has its ID and burst length stored in a small FIFO. Write
//   data beats are only let through once their address sits at the FIFO head.
//   The tracker regenerates the last-beat flag from the stored length and
//   checks the requester's flag against it. When a burst's final beat is
//   accepted it emits a one-cycle completion event carrying the burst ID.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   waddr_in_valid_i/ready  write address handshake with the requester
//   waddr_out_valid/ready   write address handshake toward the memory top
//   waddr_id_i              write address ID
//   waddr_burst_len_i       burst length, encoded as beats minus one
//   wdata_in_valid_i/ready  write data handshake with the requester
//   wdata_last_i            requester's last-beat flag
//   wdata_out_valid/ready   write data handshake toward the memory top
//   wdata_last_o            regenerated last-beat flag
//   wburst_done_valid_o     pulse, one cycle after a burst's final beat
//   wburst_done_id_o        ID of the completed burst
//   wlast_err_o             pulse, one cycle after a beat whose last flag disagreed
//   outstanding_o           number of occupied FIFO entries
module simmem_wburst_tracker #(
    parameter int IdWidth       = 4,
    parameter int BurstLenWidth = 8,
    parameter int FifoDepth     = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           waddr_in_valid_i,
    output logic                           waddr_in_ready_o,
    output logic                           waddr_out_valid_o,
    input  logic                           waddr_out_ready_i,
    input  logic [IdWidth-1:0]             waddr_id_i,
    input  logic [BurstLenWidth-1:0]       waddr_burst_len_i,
    input  logic                           wdata_in_valid_i,
    output logic                           wdata_in_ready_o,
    input  logic                           wdata_last_i,
    output logic                           wdata_out_valid_o,
    input  logic                           wdata_out_ready_i,
    output logic                           wdata_last_o,
    output logic                           wburst_done_valid_o,
    output logic [IdWidth-1:0]             wburst_done_id_o,
    output logic                           wlast_err_o,
    output logic [$clog2(FifoDepth):0]     outstanding_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    logic [IdWidth-1:0]       id_mem_q  [FifoDepth];
    logic [IdWidth-1:0]       id_mem_d  [FifoDepth];
    logic [BurstLenWidth-1:0] len_mem_q [FifoDepth];
    logic [BurstLenWidth-1:0] len_mem_d [FifoDepth];

    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [BurstLenWidth-1:0] beat_q, beat_d;
    logic                     done_valid_q, done_valid_d;
    logic [IdWidth-1:0]       done_id_q, done_id_d;
    logic                     err_q, err_d;

    logic                     empty, full;
    logic                     aw_hs, w_hs, last, pop;
    logic [IdWidth-1:0]       head_id;
    logic [BurstLenWidth-1:0] head_len;

    // While reset is held the FIFO is treated as empty and not full, so the
    // data side is closed and the address side passes straight through.
    assign empty = rst_i | (cnt_q == '0);
    assign full  = ~rst_i & (cnt_q == CntW'(FifoDepth));

    assign head_id  = id_mem_q[rd_ptr_q];
    assign head_len = len_mem_q[rd_ptr_q];

    // Full rejects an address even if a pop happens this cycle, which keeps
    // the data handshake out of the address-ready path.
    assign waddr_in_ready_o  = waddr_out_ready_i & ~full;
    assign waddr_out_valid_o = waddr_in_valid_i & ~full;
    assign aw_hs             = waddr_in_valid_i & waddr_out_ready_i & ~full;

    // Empty depends only on registered state, so a beat can never ride along
    // with the address that is being pushed in the same cycle.
    assign wdata_in_ready_o  = wdata_out_ready_i & ~empty;
    assign wdata_out_valid_o = wdata_in_valid_i & ~empty;
    assign w_hs              = wdata_in_valid_i & wdata_out_ready_i & ~empty;

    assign last         = ~empty & (beat_q == head_len);
    assign wdata_last_o = last;
    assign pop          = w_hs & last;

    assign wburst_done_valid_o = done_valid_q;
    assign wburst_done_id_o    = done_id_q;
    assign wlast_err_o         = err_q;
    assign outstanding_o       = cnt_q;

    always_comb begin
        id_mem_d     = id_mem_q;
        len_mem_d    = len_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        done_valid_d = pop;
        done_id_d    = done_id_q;
        err_d        = w_hs & (wdata_last_i != last);

        if (aw_hs) begin
            id_mem_d[wr_ptr_q]  = waddr_id_i;
            len_mem_d[wr_ptr_q] = waddr_burst_len_i;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
        end

        // Counting follows the stored length regardless of wdata_last_i.
        if (w_hs) begin
            if (last) begin
                beat_d    = '0;
                rd_ptr_d  = rd_ptr_q + PtrW'(1);
                done_id_d = head_id;
            end else begin
                beat_d = beat_q + BurstLenWidth'(1);
            end
        end

        case ({aw_hs, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        id_mem_q  <= id_mem_d;
        len_mem_q <= len_mem_d;
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_simmem_wburst_tracker.sv
module tb_simmem_wburst_tracker;

    logic       clk;
    logic       rst;
    logic       awv, awo_rdy, wv, wlast, wo_rdy;
    logic [3:0] aw_id;
    logic [7:0] aw_len;

    logic       waddr_in_ready_o, waddr_out_valid_o;
    logic       wdata_in_ready_o, wdata_out_valid_o, wdata_last_o;
    logic       wburst_done_valid_o, wlast_err_o;
    logic [3:0] wburst_done_id_o;
    logic [3:0] outstanding_o;

    simmem_wburst_tracker #(
        .IdWidth(4), .BurstLenWidth(8), .FifoDepth(8)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .waddr_in_valid_i    (awv),
        .waddr_in_ready_o    (waddr_in_ready_o),
        .waddr_out_valid_o   (waddr_out_valid_o),
        .waddr_out_ready_i   (awo_rdy),
        .waddr_id_i          (aw_id),
        .waddr_burst_len_i   (aw_len),
        .wdata_in_valid_i    (wv),
        .wdata_in_ready_o    (wdata_in_ready_o),
        .wdata_last_i        (wlast),
        .wdata_out_valid_o   (wdata_out_valid_o),
        .wdata_out_ready_i   (wo_rdy),
        .wdata_last_o        (wdata_last_o),
        .wburst_done_valid_o (wburst_done_valid_o),
        .wburst_done_id_o    (wburst_done_id_o),
        .wlast_err_o         (wlast_err_o),
        .outstanding_o       (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_len_q[$];
    logic [3:0] m_id_q[$];
    logic [3:0] exp_id_q[$];
    int         m_beat = 0;
    logic       m_dv = 1'b0;
    logic       m_err = 1'b0;
    int         n_done = 0;
    int         n_errp = 0;
    int         n_aw = 0;
    int         n_w = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check DUT against the model at the falling edge, then
    // advance the model as the rising edge will advance the DUT.
    task automatic tick();
        logic m_empty, m_full, e_aw_rdy, e_w_rdy, e_last, aw_hs, w_hs;
        logic [3:0] e_id;
        @(negedge clk);
        m_empty  = rst || (m_len_q.size() == 0);
        m_full   = !rst && (m_len_q.size() == 8);
        e_aw_rdy = awo_rdy && !m_full;
        e_w_rdy  = wo_rdy && !m_empty;
        e_last   = !m_empty && (m_beat == m_len_q[0]);

        chk("aw_in_ready",  32'(waddr_in_ready_o),  32'(e_aw_rdy));
        chk("aw_out_valid", 32'(waddr_out_valid_o), 32'(awv && !m_full));
        chk("w_in_ready",   32'(wdata_in_ready_o),  32'(e_w_rdy));
        chk("w_out_valid",  32'(wdata_out_valid_o), 32'(wv && !m_empty));
        chk("w_last_out",   32'(wdata_last_o),      32'(e_last));
        chk("outstanding",  32'(outstanding_o),     32'(m_len_q.size()));
        chk("done_valid",   32'(wburst_done_valid_o), 32'(m_dv));
        chk("wlast_err",    32'(wlast_err_o),       32'(m_err));

        if (wburst_done_valid_o === 1'b1) begin
            n_done++;
            if (exp_id_q.size() == 0) begin
                chk("done_unexpected", 32'(1), 32'(0));
            end else begin
                e_id = exp_id_q.pop_front();
                chk("done_id", 32'(wburst_done_id_o), 32'(e_id));
            end
        end
        if (wlast_err_o === 1'b1) n_errp++;

        aw_hs = awv && e_aw_rdy;
        w_hs  = wv && e_w_rdy;
        if (rst) begin
            m_len_q.delete();
            m_id_q.delete();
            exp_id_q.delete();
            m_beat = 0;
            m_dv   = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_dv  = 1'b0;
            m_err = w_hs && (wlast != e_last);
            if (w_hs) begin
                n_w++;
                if (e_last) begin
                    void'(m_len_q.pop_front());
                    void'(m_id_q.pop_front());
                    m_dv   = 1'b1;
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (aw_hs) begin
                n_aw++;
                m_len_q.push_back(int'(aw_len));
                m_id_q.push_back(aw_id);
                exp_id_q.push_back(aw_id);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, e0, a0, w0;
        rst = 1'b1; awv = 1'b0; awo_rdy = 1'b1; wv = 1'b0; wlast = 1'b0;
        wo_rdy = 1'b1; aw_id = '0; aw_len = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with address passing through while reset is held
        awv = 1'b1;
        tick();
        chk("rst_done_id", 32'(wburst_done_id_o), 32'(0));
        awv = 1'b0;
        rst = 1'b0;
        tick();

        // Single len-3 burst, ID 3
        d0 = n_done;
        awv = 1'b1; aw_id = 4'd3; aw_len = 8'd3;
        tick();
        awv = 1'b0;
        chk("t1_outstanding_1", 32'(outstanding_o), 32'(1));
        wv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wlast = (i == 3);
            tick();
        end
        wv = 1'b0; wlast = 1'b0;
        chk("t1_outstanding_0", 32'(outstanding_o), 32'(0));
        tick(); tick();
        chk("t1_done_count", 32'(n_done - d0), 32'(1));

        // Data presented before its address
        d0 = n_done; w0 = n_w;
        wv = 1'b1; wlast = 1'b1;
        tick(); tick();
        awv = 1'b1; aw_id = 4'd5; aw_len = 8'd0;
        tick();
        awv = 1'b0;
        tick();
        wv = 1'b0; wlast = 1'b0;
        tick(); tick();
        chk("t2_beats", 32'(n_w - w0), 32'(1));
        chk("t2_done_count", 32'(n_done - d0), 32'(1));

        // Fill the FIFO, ninth address stalls through the first pop
        a0 = n_aw; d0 = n_done;
        for (int i = 0; i < 8; i++) begin
            awv = 1'b1; aw_id = 4'(i); aw_len = 8'd0;
            tick();
        end
        aw_id = 4'd9;
        tick();
        chk("t3_full_count", 32'(outstanding_o), 32'(8));
        chk("t3_full_ready", 32'(waddr_in_ready_o), 32'(0));
        chk("t3_aw_count_8", 32'(n_aw - a0), 32'(8));
        wv = 1'b1; wlast = 1'b1;
        tick();
        chk("t3_stall_on_pop", 32'(n_aw - a0), 32'(8));
        tick();
        chk("t3_accept_after", 32'(n_aw - a0), 32'(9));
        awv = 1'b0;
        repeat (7) tick();
        wv = 1'b0; wlast = 1'b0;
        tick(); tick();
        chk("t3_done_count", 32'(n_done - d0), 32'(9));
        chk("t3_empty", 32'(outstanding_o), 32'(0));

        // len 0 then len 255 back to back
        d0 = n_done;
        awv = 1'b1; aw_id = 4'd1; aw_len = 8'd0;
        tick();
        aw_id = 4'd2; aw_len = 8'd255;
        tick();
        awv = 1'b0;
        wv = 1'b1;
        for (int i = 0; i < 257; i++) begin
            wlast = (i == 0) || (i == 256);
            tick();
        end
        wv = 1'b0; wlast = 1'b0;
        tick(); tick();
        chk("t4_done_count", 32'(n_done - d0), 32'(2));

        // Early last flag on beat 2 of a len-3 burst
        d0 = n_done; e0 = n_errp;
        awv = 1'b1; aw_id = 4'd6; aw_len = 8'd3;
        tick();
        awv = 1'b0;
        wv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wlast = (i == 1) || (i == 3);
            tick();
        end
        wv = 1'b0; wlast = 1'b0;
        tick(); tick();
        chk("t5_err_pulses", 32'(n_errp - e0), 32'(1));
        chk("t5_done_count", 32'(n_done - d0), 32'(1));

        // Reset mid-burst
        awv = 1'b1; aw_id = 4'd7; aw_len = 8'd2;
        tick();
        aw_id = 4'd8;
        tick();
        awv = 1'b0;
        wv = 1'b1; wlast = 1'b0;
        tick();
        wv = 1'b0;
        d0 = n_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rst_outstanding", 32'(outstanding_o), 32'(0));
        chk("t6_rst_no_done", 32'(n_done - d0), 32'(0));
        awv = 1'b1; aw_id = 4'd4; aw_len = 8'd1;
        tick();
        awv = 1'b0;
        wv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wlast = (i == 1);
            tick();
        end
        wv = 1'b0; wlast = 1'b0;
        tick(); tick();
        chk("t6_done_count", 32'(n_done - d0), 32'(1));
        chk("t6_final_empty", 32'(outstanding_o), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
